gate_tree_compare: RTL

- Parametrised successor to the 3-input gate comparison block.
- Reduces an N-bit input vector with a runtime-selectable gate (AND/OR/XOR/NAND) along two paths: a flat single-expression reduction and a pipelined tree of 2-input gate stages.
- Both results are compared cycle-aligned. Mismatches are flagged sticky and counted.
- Used as a self-checking reduction primitive and as a regression fixture for gate-level tree builders.

---
 rtl/gate_tree_compare.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/gate_tree_compare.sv
// gate_tree_compare: reduces an N-bit vector with a runtime-selected gate along two paths
// (a flat single-expression reduction and a tree of 2-input gates, optionally registered per
// level), compares the two cycle-aligned results and keeps a sticky error flag plus a
// saturating mismatch counter.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   in_data_i / op_i / inj_fault_i valid this cycle
//   in_data_i    N-bit vector to reduce
//   op_i         00 AND, 01 OR, 10 XOR, 11 NAND
//   inj_fault_i  invert the tree result of this sample
//   clr_err_i    clear err_o / err_cnt_o
//   out_valid_o  one-cycle pulse: out_tree_o / out_flat_o hold a new result
//   out_tree_o   tree-path result
//   out_flat_o   flat-path result
//   err_o        sticky mismatch flag
//   err_cnt_o    saturating mismatch count
module gate_tree_compare #(
    parameter int unsigned N     = 8,
    parameter int unsigned PIPE  = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [N-1:0]     in_data_i,
    input  logic [1:0]       op_i,
    input  logic             inj_fault_i,
    input  logic             clr_err_i,
    output logic             out_valid_o,
    output logic             out_tree_o,
    output logic             out_flat_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int unsigned L = (N > 1) ? $clog2(N) : 0;

    localparam logic [1:0] OpOr   = 2'b01;
    localparam logic [1:0] OpXor  = 2'b10;
    localparam logic [1:0] OpNand = 2'b11;

    // Width of tree level lvl: each level halves, rounding up for the odd leftover bit.
    function automatic int unsigned lvl_w(input int unsigned lvl);
        int unsigned w;
        w = N;
        for (int unsigned i = 0; i < lvl; i++) begin
            w = (w + 1) / 2;
        end
        return w;
    endfunction

    // NAND reduces as AND inside the tree; the inversion happens once at the output.
    function automatic logic gate2(input logic a, input logic b, input logic [1:0] o);
        case (o)
            OpOr:    gate2 = a | b;
            OpXor:   gate2 = a ^ b;
            default: gate2 = a & b;
        endcase
    endfunction

    // Capture stage: data, op and fault travel together from here on.
    logic         vld0_q;
    logic [N-1:0] data0_q;
    logic [1:0]   op0_q;
    logic         flt0_q;
    logic         flat0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld0_q <= 1'b0;
        end else begin
            vld0_q <= in_valid_i;
        end
        if (in_valid_i) begin
            data0_q <= in_data_i;
            op0_q   <= op_i;
            flt0_q  <= inj_fault_i;
        end
    end

    always_comb begin
        case (op0_q)
            OpOr:    flat0 = |data0_q;
            OpXor:   flat0 = ^data0_q;
            default: flat0 = &data0_q;
        endcase
    end

    // Level 0 is the captured vector; level L is the single tree bit. The flat result rides
    // alongside as sideband so both paths stay aligned.
    for (genvar l = 0; l <= L; l++) begin : g_lvl
        localparam int unsigned W = lvl_w(l);
        logic         vld;
        logic         flt;
        logic         flat;
        logic [1:0]   op;
        logic [W-1:0] val;

        if (l == 0) begin : g_base
            assign vld  = vld0_q;
            assign flt  = flt0_q;
            assign flat = flat0;
            assign op   = op0_q;
            assign val  = data0_q;
        end else begin : g_step
            localparam int unsigned PW = lvl_w(l - 1);
            logic [W-1:0] val_d;

            for (genvar i = 0; i < W; i++) begin : g_bit
                if (2 * i + 1 < PW) begin : g_pair
                    assign val_d[i] = gate2(g_lvl[l-1].val[2*i], g_lvl[l-1].val[2*i+1],
                                            g_lvl[l-1].op);
                end else begin : g_pass
                    assign val_d[i] = g_lvl[l-1].val[2*i];
                end
            end

            if (PIPE != 0) begin : g_reg
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        vld <= 1'b0;
                    end else begin
                        vld <= g_lvl[l-1].vld;
                    end
                    val  <= val_d;
                    op   <= g_lvl[l-1].op;
                    flt  <= g_lvl[l-1].flt;
                    flat <= g_lvl[l-1].flat;
                end
            end else begin : g_comb
                assign vld  = g_lvl[l-1].vld;
                assign val  = val_d;
                assign op   = g_lvl[l-1].op;
                assign flt  = g_lvl[l-1].flt;
                assign flat = g_lvl[l-1].flat;
            end
        end
    end

    logic top_vld;
    logic top_nand;
    logic tree_bit;
    logic flat_bit;

    assign top_vld  = g_lvl[L].vld;
    assign top_nand = (g_lvl[L].op == OpNand);
    assign tree_bit = g_lvl[L].val[0] ^ top_nand ^ g_lvl[L].flt;
    assign flat_bit = g_lvl[L].flat ^ top_nand;

    logic out_valid_q;
    logic out_tree_q;
    logic out_flat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_tree_q  <= 1'b0;
            out_flat_q  <= 1'b0;
        end else begin
            out_valid_q <= top_vld;
            if (top_vld) begin
                out_tree_q <= tree_bit;
                out_flat_q <= flat_bit;
            end
        end
    end

    // Compare works on the registered outputs, so error state trails out_valid by one cycle.
    logic             mismatch;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    assign mismatch = out_valid_q & (out_tree_q ^ out_flat_q);

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (clr_err_i) begin
            // A mismatch arriving with the clear is kept as the first new event.
            err_d     = mismatch;
            err_cnt_d = mismatch ? CNT_W'(1) : '0;
        end else if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_tree_o  = out_tree_q;
    assign out_flat_o  = out_flat_q;
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule
